key_debounce: RTL and testbench
===============================

# key_debounce

Multi-channel push-button conditioner that sits directly upstream of the stopwatch control logic on the DE1-SoC. It synchronises the raw active-low KEY inputs, rejects bounce shorter than a programmable stable time, and emits clean signals to the stopwatch:

- a debounced level per key;
- single-cycle press and release pulses per key;
- a per-key toggle flag that directly drives the stopwatch's run/pause and display-freeze state bits.

## Interface

Parameters:
- N_KEYS, 3, number of independent key channels.
- DEBOUNCE_CYCLES, 500000, consecutive stable synchronised samples required to accept a level change (10 ms at 50 MHz). Legal range is 2 or more.
- CNT_W, 20, stable-counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  in  1  50 MHz system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- key_n  in  N_KEYS  raw board keys, active-low (0 = pressed), asynchronous to clk.
- key_level  out  N_KEYS  debounced state, 1 = pressed.
- key_press  out  N_KEYS  one-cycle pulse when a debounced press is accepted.
- key_release  out  N_KEYS  one-cycle pulse when a debounced release is accepted.
- key_toggle  out  N_KEYS  inverts on every accepted press.

## Operation

The channels are fully independent and identical; bit i of every port belongs to channel i.

**Synchroniser**
- Two-flop synchroniser per channel on key_n.
- The synchronised signal s is inverted so that s=1 means pressed.
- Both flops reset to "not pressed".

**Per-channel FSM (4 states)**
- IDLE (level 0):
  - if s=1, go to PRESS_WAIT with cnt=1;
  - otherwise stay, cnt=0.
- PRESS_WAIT (level 0):
  - if s=0, go to IDLE with cnt=0 (bounce rejected, no output activity);
  - if s=1 and cnt=DEBOUNCE_CYCLES-1, go to PRESSED with level←1, press←1, toggle←~toggle, cnt←0;
  - otherwise cnt←cnt+1.
- PRESSED (level 1): mirror of IDLE with s inverted.
  - if s=0, go to RELEASE_WAIT with cnt=1.
- RELEASE_WAIT (level 1):
  - if s=1, go to PRESSED with cnt=0;
  - if s=0 and cnt=DEBOUNCE_CYCLES-1, go to IDLE with level←0, release←1, cnt←0;
  - otherwise cnt←cnt+1.

**Output rules**
- key_press and key_release are registered and high for exactly one clk cycle per accepted transition. They are never both high on the same channel in the same cycle.
- key_level, key_toggle and the pulses are all registered outputs with no combinational path from key_n.
- cnt never exceeds DEBOUNCE_CYCLES-1 and never wraps.
- A key held indefinitely produces exactly one press pulse; auto-repeat is not provided.

## Timing

**Reset values**
- All outputs 0.
- All FSMs in IDLE, cnt=0, synchroniser flops at "not pressed".
- Reset asserted mid-debounce or while PRESSED aborts immediately. No release pulse is generated.

**Latency**
- Let key_n[i] go low just before rising edge k and stay low.
- s[i] is 1 from edge k+2.
- key_level[i], key_press[i] and the key_toggle change all appear at edge k+1+DEBOUNCE_CYCLES.
- Release is symmetric: key_level falls and key_release pulses DEBOUNCE_CYCLES+1 edges after key_n returns high.

**Boundary conditions**
- A glitch of fewer than DEBOUNCE_CYCLES synchronised cycles is fully ignored.
- Exactly DEBOUNCE_CYCLES cycles is accepted.
- Any opposite sample restarts qualification from zero; there is no accumulation across bounces.
- If a key is held low while rst deasserts, it is treated as a fresh press and accepted DEBOUNCE_CYCLES+1 edges after the first edge following deassertion.
- Simultaneous activity on several channels is handled independently with no interaction.
- Pulses may coincide across channels.

## Test plan

All scenarios use DEBOUNCE_CYCLES=4 and CNT_W=3.

1. **Reset:** assert rst with key_n=3'b000 -> all outputs 0. Deassert rst at edge 0 -> key_level=3'b111, key_press=3'b111 for exactly one cycle at edge 5, key_toggle=3'b111.
2. **Clean press/release, ch0:** key_n[0] low before edge 10, high before edge 30 -> key_press[0] pulses at edge 15, key_level[0]=1 for edges 15–34, key_release[0] pulses at edge 35, key_toggle[0]=1 from edge 15.
3. **Bounce rejection, ch1:** key_n[1] low for 3 cycles, high for 1, low for 3, then high -> no change on any output, cnt returns to 0.
4. **Bounce then settle, ch1:** same as scenario 3, but the final low segment is held -> a single key_press[1] pulse 5 edges after the start of the final low segment.
5. **Toggle sequence, ch2:** three clean press/release cycles -> key_toggle[2] follows 1, 0, 1. Exactly three press pulses and three release pulses.
6. **Reset mid-operation:** rst asserted while ch0 is PRESSED and ch1 is in PRESS_WAIT -> outputs immediately 0, no release pulse. After deassertion with the keys released, no activity occurs.

Source files
------------

// File: rtl/key_debounce.sv
// key_debounce: multi-channel push-button conditioner for active-low board keys.
// Each channel synchronises its key, qualifies level changes over DEBOUNCE_CYCLES
// stable samples, and emits a registered level, press/release pulses and a toggle.
// Ports:
//   clk         in   rising-edge system clock
//   rst         in   asynchronous active-high reset
//   key_n       in   [N_KEYS] raw keys, 0 = pressed, asynchronous to clk
//   key_level   out  [N_KEYS] debounced state, 1 = pressed
//   key_press   out  [N_KEYS] one-cycle pulse on an accepted press
//   key_release out  [N_KEYS] one-cycle pulse on an accepted release
//   key_toggle  out  [N_KEYS] inverts on every accepted press
module key_debounce #(
    parameter int N_KEYS          = 3,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_n,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_toggle
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Synchroniser flops hold raw key polarity; reset value 1 = not pressed.
    logic [N_KEYS-1:0] sync1_q;
    logic [N_KEYS-1:0] sync2_q;
    logic [N_KEYS-1:0] s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= key_n;
            sync2_q <= sync1_q;
        end
    end

    assign s = ~sync2_q;

    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        state_t           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             level_q, level_d;
        logic             press_q, press_d;
        logic             release_q, release_d;
        logic             toggle_q, toggle_d;

        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            level_d   = level_q;
            toggle_d  = toggle_q;
            press_d   = 1'b0;
            release_d = 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (s[i]) begin
                        state_d = PRESS_WAIT;
                        cnt_d   = CNT_ONE;
                    end else begin
                        cnt_d = '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!s[i]) begin
                        // Bounce: restart qualification from zero.
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d  = PRESSED;
                        cnt_d    = '0;
                        level_d  = 1'b1;
                        press_d  = 1'b1;
                        toggle_d = ~toggle_q;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                PRESSED: begin
                    if (!s[i]) begin
                        state_d = RELEASE_WAIT;
                        cnt_d   = CNT_ONE;
                    end else begin
                        cnt_d = '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (s[i]) begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d   = IDLE;
                        cnt_d     = '0;
                        level_d   = 1'b0;
                        release_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q   <= IDLE;
                cnt_q     <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                toggle_q  <= 1'b0;
            end else begin
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                level_q   <= level_d;
                press_q   <= press_d;
                release_q <= release_d;
                toggle_q  <= toggle_d;
            end
        end

        assign key_level[i]   = level_q;
        assign key_press[i]   = press_q;
        assign key_release[i] = release_q;
        assign key_toggle[i]  = toggle_q;
    end

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: directed self-checking bench for key_debounce
// with DEBOUNCE_CYCLES=4, CNT_W=3, three channels.
module tb_key_debounce;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] key_n = 3'b111;
    logic [2:0] key_level;
    logic [2:0] key_press;
    logic [2:0] key_release;
    logic [2:0] key_toggle;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int n_pr  = 0;
    int n_rl  = 0;

    key_debounce #(
        .N_KEYS         (3),
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_n      (key_n),
        .key_level  (key_level),
        .key_press  (key_press),
        .key_release(key_release),
        .key_toggle (key_toggle)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @edge %0d: got %0h expected %0h",
                     tag, cyc, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [2:0] lv,
                           input logic [2:0] pr, input logic [2:0] rl,
                           input logic [2:0] tg);
        chk({tag, ".level"},   32'(key_level),   32'(lv));
        chk({tag, ".press"},   32'(key_press),   32'(pr));
        chk({tag, ".release"}, 32'(key_release), 32'(rl));
        chk({tag, ".toggle"},  32'(key_toggle),  32'(tg));
    endtask

    // Advance one rising edge and settle; cyc names the edge just taken.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        key_n = 3'b111;
        tick();
        tick();
        rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        // 1: reset with all keys held down, then fresh press after release of rst
        rst   = 1'b1;
        key_n = 3'b000;
        #2;
        chk_all("rst_async", 3'b000, 3'b000, 3'b000, 3'b000);
        tick();
        tick();
        tick();
        chk_all("rst_hold", 3'b000, 3'b000, 3'b000, 3'b000);
        rst = 1'b0;
        cyc = -1;
        repeat (8) begin
            tick();
            chk_all("s1_press",
                    (cyc >= 5) ? 3'b111 : 3'b000,
                    (cyc == 5) ? 3'b111 : 3'b000,
                    3'b000,
                    (cyc >= 5) ? 3'b111 : 3'b000);
        end
        key_n = 3'b111;
        repeat (8) begin
            tick();
            chk_all("s1_release",
                    (cyc >= 13) ? 3'b000 : 3'b111,
                    3'b000,
                    (cyc == 13) ? 3'b111 : 3'b000,
                    3'b111);
        end

        // 2: clean press/release on ch0
        do_reset();
        chk_all("s2_rst", 3'b000, 3'b000, 3'b000, 3'b000);
        while (cyc < 40) begin
            if (cyc == 9)  key_n[0] = 1'b0;
            if (cyc == 29) key_n[0] = 1'b1;
            tick();
            chk_all("s2",
                    (cyc >= 15 && cyc <= 34) ? 3'b001 : 3'b000,
                    (cyc == 15) ? 3'b001 : 3'b000,
                    (cyc == 35) ? 3'b001 : 3'b000,
                    (cyc >= 15) ? 3'b001 : 3'b000);
        end

        // 3: bounce 3 low / 1 high / 3 low / high on ch1 -> nothing
        do_reset();
        while (cyc < 20) begin
            if (cyc == 0)  key_n[1] = 1'b0;
            if (cyc == 3)  key_n[1] = 1'b1;
            if (cyc == 4)  key_n[1] = 1'b0;
            if (cyc == 7)  key_n[1] = 1'b1;
            tick();
            chk_all("s3", 3'b000, 3'b000, 3'b000, 3'b000);
        end

        // 4: bounce then settle on ch1; final low segment starts at edge 9
        do_reset();
        while (cyc < 22) begin
            if (cyc == 0) key_n[1] = 1'b0;
            if (cyc == 3) key_n[1] = 1'b1;
            if (cyc == 4) key_n[1] = 1'b0;
            if (cyc == 7) key_n[1] = 1'b1;
            if (cyc == 8) key_n[1] = 1'b0;
            tick();
            chk_all("s4",
                    (cyc >= 14) ? 3'b010 : 3'b000,
                    (cyc == 14) ? 3'b010 : 3'b000,
                    3'b000,
                    (cyc >= 14) ? 3'b010 : 3'b000);
        end

        // 5: three exactly-minimum presses on ch2
        do_reset();
        n_pr = 0;
        n_rl = 0;
        while (cyc < 40) begin
            if (cyc == 0 || cyc == 12 || cyc == 24) key_n[2] = 1'b0;
            if (cyc == 4 || cyc == 16 || cyc == 28) key_n[2] = 1'b1;
            tick();
            if (key_press[2])   n_pr++;
            if (key_release[2]) n_rl++;
            chk_all("s5",
                    ((cyc >= 6 && cyc <= 9) || (cyc >= 18 && cyc <= 21) ||
                     (cyc >= 30 && cyc <= 33)) ? 3'b100 : 3'b000,
                    (cyc == 6 || cyc == 18 || cyc == 30) ? 3'b100 : 3'b000,
                    (cyc == 10 || cyc == 22 || cyc == 34) ? 3'b100 : 3'b000,
                    ((cyc >= 6 && cyc < 18) || cyc >= 30) ? 3'b100 : 3'b000);
        end
        chk("s5_npress", 32'(n_pr), 32'd3);
        chk("s5_nrelease", 32'(n_rl), 32'd3);

        // 6: reset while ch0 PRESSED and ch1 in PRESS_WAIT
        do_reset();
        while (cyc < 11) begin
            if (cyc == 0) key_n[0] = 1'b0;
            if (cyc == 7) key_n[1] = 1'b0;
            tick();
        end
        chk_all("s6_pre", 3'b001, 3'b000, 3'b000, 3'b001);
        rst = 1'b1;
        #1;
        chk_all("s6_async", 3'b000, 3'b000, 3'b000, 3'b000);
        key_n = 3'b111;
        tick();
        tick();
        rst = 1'b0;
        cyc = 0;
        while (cyc < 15) begin
            tick();
            chk_all("s6_post", 3'b000, 3'b000, 3'b000, 3'b000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
